// File: rtl/lpc_mem_arbiter.sv
// Two-requester arbiter for one port of the LPC sample RAM: zero-cycle grant, locked bursts
// capped at MAX_BURST, round-robin ties. Optional grant counters under LPC_MEM_ARB_STATS_EN.
module lpc_mem_arbiter #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic                  m0_lock,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_gnt,
    output logic                  m0_rdvalid,
    output logic [DATA_W-1:0]     m0_readdata,
    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic                  m1_lock,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_gnt,
    output logic                  m1_rdvalid,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
`ifdef LPC_MEM_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [15:0]           m0_gnt_count,
    output logic [15:0]           m1_gnt_count
`endif
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last, last_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic              gnt0_c, gnt1_c;
    logic [BEAT_W-1:0] beat_inc_c;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            beat  <= beat_nxt;
        end
    end

    assign beat_inc_c = (beat >= BEAT_MAX) ? BEAT_MAX : beat + BEAT_W'(1);

    // Grant decision and next state; a locked owner keeps the port until its burst cap
    always_comb begin
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        state_nxt = IDLE;
        last_nxt  = last;
        beat_nxt  = '0;
        if (!reset_n) begin
            gnt0_c = 1'b0;
        end else if (state == OWN0 && m0_req && m0_lock && beat < BEAT_MAX) begin
            gnt0_c = 1'b1;
        end else if (state == OWN1 && m1_req && m1_lock && beat < BEAT_MAX) begin
            gnt1_c = 1'b1;
        end else if (m0_req && !m1_req) begin
            gnt0_c = 1'b1;
        end else if (m1_req && !m0_req) begin
            gnt1_c = 1'b1;
        end else if (m0_req && m1_req) begin
            gnt0_c = last;
            gnt1_c = !last;
        end

        if (gnt0_c) begin
            state_nxt = OWN0;
            last_nxt  = 1'b0;
            beat_nxt  = (state == OWN0) ? beat_inc_c : BEAT_W'(1);
        end else if (gnt1_c) begin
            state_nxt = OWN1;
            last_nxt  = 1'b1;
            beat_nxt  = (state == OWN1) ? beat_inc_c : BEAT_W'(1);
        end
    end

    // Memory command mux; idle port drives zeros
    always_comb begin
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        if (gnt0_c) begin
            mem_address    = m0_address;
            mem_writedata  = m0_writedata;
            mem_byteenable = m0_byteenable;
        end else if (gnt1_c) begin
            mem_address    = m1_address;
            mem_writedata  = m1_writedata;
            mem_byteenable = m1_byteenable;
        end
    end

    assign m0_gnt         = gnt0_c;
    assign m1_gnt         = gnt1_c;
    assign mem_chipselect = gnt0_c | gnt1_c;
    assign mem_write      = (gnt0_c & m0_write) | (gnt1_c & m1_write);
    assign mem_clken      = 1'b1;
    assign m0_readdata    = mem_readdata;
    assign m1_readdata    = mem_readdata;

    // RAM has one cycle of read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rdvalid <= 1'b0;
            m1_rdvalid <= 1'b0;
        end else begin
            m0_rdvalid <= gnt0_c & ~m0_write;
            m1_rdvalid <= gnt1_c & ~m1_write;
        end
    end

`ifdef LPC_MEM_ARB_STATS_EN
    // Saturating grant counters; clear wins over increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_gnt_count <= '0;
            m1_gnt_count <= '0;
        end else if (stats_clr) begin
            m0_gnt_count <= '0;
            m1_gnt_count <= '0;
        end else begin
            if (gnt0_c && m0_gnt_count != 16'hFFFF) m0_gnt_count <= m0_gnt_count + 16'd1;
            if (gnt1_c && m1_gnt_count != 16'hFFFF) m1_gnt_count <= m1_gnt_count + 16'd1;
        end
    end
`endif

    logic unused_c;
    assign unused_c = ^{BE_W};

endmodule

// File: tb/tb_lpc_mem_arbiter.sv
// Scoreboard bench for lpc_mem_arbiter: stimulus pushes model-predicted cycle records,
// a negedge monitor pops and compares. Covers LPC_MEM_ARB_STATS_EN when defined.
module tb_lpc_mem_arbiter;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_write, m0_lock, m1_req, m1_write, m1_lock;
    logic [12:0] m0_address, m1_address;
    logic [15:0] m0_writedata, m1_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_gnt, m1_gnt, m0_rdvalid, m1_rdvalid;
    logic [15:0] m0_readdata, m1_readdata;
    logic [12:0] mem_address;
    logic [15:0] mem_writedata, mem_readdata;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
`ifdef LPC_MEM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] m0_gnt_count, m1_gnt_count;
`endif

    lpc_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_write(m0_write), .m0_lock(m0_lock),
        .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_gnt(m0_gnt), .m0_rdvalid(m0_rdvalid), .m0_readdata(m0_readdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_lock(m1_lock),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_gnt(m1_gnt), .m1_rdvalid(m1_rdvalid), .m1_readdata(m1_readdata),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
`ifdef LPC_MEM_ARB_STATS_EN
        , .stats_clr(stats_clr), .m0_gnt_count(m0_gnt_count), .m1_gnt_count(m1_gnt_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 37 + 5);
    endfunction

    // RAM model attached to the DUT memory port
    logic [15:0] ram [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_chipselect && mem_clken) begin
                if (mem_write) begin
                    if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
                    if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
                end else begin
                    mem_readdata <= ram[mem_address];
                end
            end
        end
    end

    typedef struct {
        bit          g0, g1, cs, wr, v0, v1;
        logic [12:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic [15:0] rd;
        logic [15:0] c0, c1;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest predicted record
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("gnt", 64'({m0_gnt, m1_gnt}), 64'({e.g0, e.g1}));
            chk("mem_cmd", 64'({mem_chipselect, mem_write, mem_clken, mem_address, mem_writedata, mem_byteenable}),
                64'({e.cs, e.wr, 1'b1, e.a, e.d, e.be}));
            chk("rdvalid", 64'({m0_rdvalid, m1_rdvalid}), 64'({e.v0, e.v1}));
            if (e.v0) chk("m0_readdata", 64'(m0_readdata), 64'(e.rd));
            if (e.v1) chk("m1_readdata", 64'(m1_readdata), 64'(e.rd));
`ifdef LPC_MEM_ARB_STATS_EN
            chk("gnt_count", 64'({m0_gnt_count, m1_gnt_count}), 64'({e.c0, e.c1}));
`endif
        end
    end

    // Reference model
    logic [15:0] ref_mem [0:8191];
    int          owner, last_m, beat_m, cnt0, cnt1;
    bit          pend_v0, pend_v1;
    logic [15:0] pend_d;

    task automatic step();
        exp_t        e;
        int          g;
        bit          req [2];
        bit          lck [2];
        bit          wr  [2];
        logic [12:0] ad  [2];
        logic [15:0] wd  [2];
        logic [1:0]  bb  [2];
        e = '{default: 0};
        req = '{m0_req, m1_req};       lck = '{m0_lock, m1_lock};
        wr  = '{m0_write, m1_write};   ad  = '{m0_address, m1_address};
        wd  = '{m0_writedata, m1_writedata}; bb = '{m0_byteenable, m1_byteenable};
        if (!reset_n) begin
            owner = -1; last_m = 1; beat_m = 0; pend_v0 = 0; pend_v1 = 0; cnt0 = 0; cnt1 = 0;
        end else begin
            e.v0 = pend_v0; e.v1 = pend_v1; e.rd = pend_d;
            e.c0 = 16'(cnt0); e.c1 = 16'(cnt1);
            g = -1;
            if (owner >= 0 && req[owner] && lck[owner] && beat_m < MAXB) g = owner;
            else if (req[0] != req[1]) g = req[0] ? 0 : 1;
            else if (req[0] && req[1]) g = 1 - last_m;
            pend_v0 = 0; pend_v1 = 0;
            if (g >= 0) begin
                e.g0 = (g == 0); e.g1 = (g == 1); e.cs = 1; e.wr = wr[g];
                e.a = ad[g]; e.d = wd[g]; e.be = bb[g];
                if (wr[g]) begin
                    if (bb[g][0]) ref_mem[ad[g]][7:0]  = wd[g][7:0];
                    if (bb[g][1]) ref_mem[ad[g]][15:8] = wd[g][15:8];
                end else begin
                    pend_d = ref_mem[ad[g]];
                    if (g == 0) pend_v0 = 1; else pend_v1 = 1;
                end
                beat_m = (g == owner) ? ((beat_m + 1 > MAXB) ? MAXB : beat_m + 1) : 1;
                owner = g; last_m = g;
                if (g == 0 && cnt0 < 65535) cnt0++;
                if (g == 1 && cnt1 < 65535) cnt1++;
            end else begin
                owner = -1; beat_m = 0;
            end
`ifdef LPC_MEM_ARB_STATS_EN
            if (stats_clr) begin cnt0 = 0; cnt1 = 0; end
`endif
        end
        q.push_back(e);
        @(posedge clk); #2;
    endtask

    task automatic set_m(input int n, input bit r, input bit w, input bit l,
                         input logic [12:0] a, input logic [15:0] d, input logic [1:0] b);
        if (n == 0) begin
            m0_req = r; m0_write = w; m0_lock = l; m0_address = a; m0_writedata = d; m0_byteenable = b;
        end else begin
            m1_req = r; m1_write = w; m1_lock = l; m1_address = a; m1_writedata = d; m1_byteenable = b;
        end
    endtask

    task automatic idle_all();
        set_m(0, 0, 0, 0, 13'h0, 16'h0, 2'b00);
        set_m(1, 0, 0, 0, 13'h0, 16'h0, 2'b00);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        idle_all();
`ifdef LPC_MEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
        owner = -1; last_m = 1; beat_m = 0; cnt0 = 0; cnt1 = 0;
        pend_v0 = 0; pend_v1 = 0; pend_d = '0;
        @(posedge clk); #2;

        // Requests during reset must not be granted
        set_m(0, 1, 0, 1, 13'h3, 16'h0, 2'b11);
        set_m(1, 1, 1, 1, 13'h4, 16'h1, 2'b11);
        repeat (3) step();
        idle_all();
        reset_n = 1'b1;
        step();

        // Simultaneous first requests: m0, m1, then alternating
        set_m(0, 1, 0, 0, 13'h10, 16'h0, 2'b11);
        set_m(1, 1, 0, 0, 13'h11, 16'h0, 2'b11);
        repeat (4) step();
        idle_all();
        step();

        // Seed 0x0005 with 0x1234 via m1, then m0 reads it
        set_m(1, 1, 1, 0, 13'h0005, 16'h1234, 2'b11);
        step();
        idle_all();
        set_m(0, 1, 0, 0, 13'h0005, 16'h0, 2'b11);
        step();
        idle_all();
        step();

        // m1 locked burst against waiting m0: 16 m1 grants then hand-over
        set_m(0, 1, 0, 0, 13'h20, 16'h0, 2'b11);
        step();
        set_m(1, 1, 0, 1, 13'h21, 16'h0, 2'b11);
        repeat (20) step();
        idle_all();
        step();

        // m0 locked alone for 20 cycles, then m1 arrives and takes over at once
        set_m(0, 1, 0, 1, 13'h30, 16'h0, 2'b11);
        repeat (20) step();
        set_m(1, 1, 0, 0, 13'h31, 16'h0, 2'b11);
        repeat (2) step();
        idle_all();
        step();

        // m1 partial write to top address, then read back through m0
        set_m(1, 1, 1, 0, 13'h1FFF, 16'hBEEF, 2'b10);
        step();
        idle_all();
        set_m(0, 1, 0, 0, 13'h1FFF, 16'h0, 2'b11);
        step();
        idle_all();
        step();

        // Randomized traffic on a small address window
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 2; n++)
                set_m(n, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 9) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15)),
                      16'($urandom), 2'($urandom_range(0, 3)));
            step();
        end

        // Reset asserted mid-burst of reads: no stale rdvalid afterwards
        set_m(0, 1, 0, 1, 13'h7, 16'h0, 2'b11);
        set_m(1, 1, 0, 0, 13'h8, 16'h0, 2'b11);
        repeat (3) step();
        reset_n = 1'b0;
        repeat (2) step();
        idle_all();
        reset_n = 1'b1;
        repeat (3) step();

`ifdef LPC_MEM_ARB_STATS_EN
        // Counter saturation, then clear colliding with a grant
        set_m(0, 1, 0, 0, 13'h40, 16'h0, 2'b11);
        repeat (65535 + 3) step();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        repeat (2) step();
        idle_all();
        step();
`endif

        idle_all();
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
